// File: rtl/display_line_editor.sv
// Character line buffer for the Morse display path: append, backspace (synchronised button),
// replace-newest, clear, and scroll-or-reject on a full line. Slot 0 holds the newest character.
module display_line_editor #(
   parameter int unsigned       CHAR_W = 8,
   parameter int unsigned       DEPTH  = 8,
   parameter bit                SCROLL = 1'b1,
   parameter logic [CHAR_W-1:0] BLANK  = '0,
   localparam int unsigned      CW     = $clog2(DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [CHAR_W-1:0]          push_char,
   input  logic                       bs_btn,
   input  logic                       clear,
   output logic [CHAR_W*DEPTH-1:0]    line,
   output logic [CW-1:0]              count,
   output logic                       empty,
   output logic                       full,
   output logic                       err
);

   logic [CHAR_W-1:0] r_slot [DEPTH];
   logic [CW-1:0]     r_count;
   logic              r_empty;
   logic              r_full;
   logic              r_err;
   logic              r_bs_s0;
   logic              r_bs_s1;
   logic              r_bs_s2;

   logic [CHAR_W-1:0] w_slot_d [DEPTH];
   logic [CW-1:0]     w_count_d;
   logic              w_err_d;
   logic              w_bs_pulse;

   assign w_bs_pulse = r_bs_s1 & ~r_bs_s2;

   // One action per cycle; earlier branches take priority over later ones.
   always_comb begin
      w_slot_d  = r_slot;
      w_count_d = r_count;
      w_err_d   = 1'b0;
      if (clear) begin
         for (int i = 0; i < DEPTH; i++) w_slot_d[i] = BLANK;
         w_count_d = '0;
      end else if (w_bs_pulse && push && (r_count != '0)) begin
         w_slot_d[0] = push_char;
      end else if (w_bs_pulse && !push) begin
         if (r_count != '0) begin
            for (int i = 0; i < DEPTH - 1; i++) w_slot_d[i] = r_slot[i+1];
            w_slot_d[DEPTH-1] = BLANK;
            w_count_d         = r_count - CW'(1);
         end
      end else if (push) begin
         if (!r_full || SCROLL) begin
            for (int i = 1; i < DEPTH; i++) w_slot_d[i] = r_slot[i-1];
            w_slot_d[0] = push_char;
            if (!r_full) w_count_d = r_count + CW'(1);
         end else begin
            w_err_d = 1'b1;
         end
      end
   end

   // Sync flops reset high so a button held through reset never yields a backspace.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_slot[i] <= BLANK;
         r_count <= '0;
         r_empty <= 1'b1;
         r_full  <= 1'b0;
         r_err   <= 1'b0;
         r_bs_s0 <= 1'b1;
         r_bs_s1 <= 1'b1;
         r_bs_s2 <= 1'b1;
      end else begin
         r_slot  <= w_slot_d;
         r_count <= w_count_d;
         r_empty <= (w_count_d == '0);
         r_full  <= (w_count_d == CW'(DEPTH));
         r_err   <= w_err_d;
         r_bs_s0 <= bs_btn;
         r_bs_s1 <= r_bs_s0;
         r_bs_s2 <= r_bs_s1;
      end
   end

   always_comb begin
      line = '0;
      for (int i = 0; i < DEPTH; i++) line[i*CHAR_W +: CHAR_W] = r_slot[i];
   end

   assign count = r_count;
   assign empty = r_empty;
   assign full  = r_full;
   assign err   = r_err;

endmodule

// File: tb/tb_display_line_editor.sv
// Bench for display_line_editor: a scrolling and a rejecting instance share stimulus and are
// compared every cycle against a queue-based model, plus a vector table and directed sequences.
module tb_display_line_editor;

   localparam int unsigned D = 8;

   typedef logic [7:0] cq_t[$];

   typedef struct {
      bit          rst;
      bit          push;
      logic [7:0]  ch;
      bit          clear;
      int          exp_count;
      logic [63:0] exp_line;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        push;
   logic [7:0]  push_char;
   logic        bs_btn;
   logic        clear;

   logic [63:0] line_s, line_r;
   logic [3:0]  count_s, count_r;
   logic        empty_s, empty_r, full_s, full_r, err_s, err_r;

   int n_chk;
   int n_err;

   cq_t q_s, q_r;
   bit  me_s, me_r;
   bit  h1, h2, h3;

   display_line_editor #(.CHAR_W(8), .DEPTH(D), .SCROLL(1'b1), .BLANK(8'h00)) u_s (
      .clk(clk), .rst(rst), .push(push), .push_char(push_char), .bs_btn(bs_btn),
      .clear(clear), .line(line_s), .count(count_s), .empty(empty_s), .full(full_s),
      .err(err_s)
   );

   display_line_editor #(.CHAR_W(8), .DEPTH(D), .SCROLL(1'b0), .BLANK(8'h00)) u_r (
      .clk(clk), .rst(rst), .push(push), .push_char(push_char), .bs_btn(bs_btn),
      .clear(clear), .line(line_r), .count(count_r), .empty(empty_r), .full(full_r),
      .err(err_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] line_of(input cq_t q);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < q.size(); i++) r[i*8 +: 8] = q[i];
      return r;
   endfunction

   // Model of one line: front of the queue is the newest character.
   task automatic step_q(input cq_t qi, input bit scroll, input bit pulse, output cq_t qo,
                         output bit e);
      qo = qi;
      e  = 1'b0;
      if (clear) begin
         qo = {};
      end else if (pulse && push && qo.size() > 0) begin
         qo[0] = push_char;
      end else if (pulse && !push) begin
         if (qo.size() > 0) void'(qo.pop_front());
      end else if (push) begin
         if (qo.size() < D) begin
            qo.push_front(push_char);
         end else if (scroll) begin
            void'(qo.pop_back());
            qo.push_front(push_char);
         end else begin
            e = 1'b1;
         end
      end
   endtask

   task automatic check_dut(input string nm, input logic [63:0] l, input logic [3:0] c,
                            input logic em, input logic fu, input logic er, input cq_t q,
                            input bit me);
      chk({nm, ".line"}, l, line_of(q));
      chk({nm, ".count"}, 64'(c), 64'(q.size()));
      chk({nm, ".empty"}, 64'(em), 64'(q.size() == 0));
      chk({nm, ".full"}, 64'(fu), 64'(q.size() == D));
      chk({nm, ".err"}, 64'(er), 64'(me));
   endtask

   task automatic tick();
      bit   pulse;
      cq_t  t;
      @(posedge clk);
      if (rst) begin
         q_s = {};
         q_r = {};
         me_s = 1'b0;
         me_r = 1'b0;
         h1 = 1'b1;
         h2 = 1'b1;
         h3 = 1'b1;
      end else begin
         // Button sampled two edges ago is high and three edges ago was low.
         pulse = h2 & ~h3;
         h3 = h2;
         h2 = h1;
         h1 = bs_btn;
         step_q(q_s, 1'b1, pulse, t, me_s);
         q_s = t;
         step_q(q_r, 1'b0, pulse, t, me_r);
         q_r = t;
      end
      #1;
      check_dut("scroll", line_s, count_s, empty_s, full_s, err_s, q_s, me_s);
      check_dut("reject", line_r, count_r, empty_r, full_r, err_r, q_r, me_r);
   endtask

   task automatic idle(input int n);
      push  = 1'b0;
      clear = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic push_c(input logic [7:0] c);
      push      = 1'b1;
      push_char = c;
      tick();
      push = 1'b0;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      push  = 1'b0;
      clear = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   vec_t tbl[7];
   int   bs_left;

   initial begin
      n_chk = 0;
      n_err = 0;
      rst = 1'b1;
      push = 1'b0;
      push_char = 8'h00;
      bs_btn = 1'b0;
      clear = 1'b0;
      h1 = 1'b1;
      h2 = 1'b1;
      h3 = 1'b1;

      tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 64'h0};
      tbl[1] = '{1'b0, 1'b1, 8'h11, 1'b0, 1, 64'h11};
      tbl[2] = '{1'b0, 1'b1, 8'h22, 1'b0, 2, 64'h1122};
      tbl[3] = '{1'b0, 1'b1, 8'h33, 1'b0, 3, 64'h112233};
      tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 3, 64'h112233};
      tbl[5] = '{1'b0, 1'b1, 8'h44, 1'b1, 0, 64'h0};
      tbl[6] = '{1'b0, 1'b1, 8'h7E, 1'b0, 1, 64'h7E};
      for (int i = 0; i < 7; i++) begin
         rst       = tbl[i].rst;
         push      = tbl[i].push;
         push_char = tbl[i].ch;
         clear     = tbl[i].clear;
         tick();
         chk($sformatf("vec%0d.count", i), 64'(count_s), 64'(tbl[i].exp_count));
         chk($sformatf("vec%0d.line", i), line_s, tbl[i].exp_line);
      end
      rst = 1'b0;
      idle(1);

      // One backspace per held press, two edges after first sample.
      do_reset();
      idle(3);
      push_c(8'h11);
      push_c(8'h22);
      push_c(8'h33);
      bs_btn = 1'b1;
      tick();
      chk("bs.k", 64'(count_s), 64'd3);
      tick();
      chk("bs.k1", 64'(count_s), 64'd3);
      tick();
      chk("bs.k2.count", 64'(count_s), 64'd2);
      chk("bs.k2.line", line_s, 64'h1122);
      idle(17);
      chk("bs.held", 64'(count_s), 64'd2);
      bs_btn = 1'b0;
      idle(3);
      bs_btn = 1'b1;
      idle(5);
      chk("bs.second", 64'(count_s), 64'd1);
      bs_btn = 1'b0;

      // Full line: scroll instance drops oldest, reject instance pulses err once.
      do_reset();
      idle(3);
      for (int i = 1; i <= 8; i++) push_c(8'(i));
      push_c(8'h09);
      chk("scroll.full", 64'(full_s), 64'd1);
      chk("scroll.count", 64'(count_s), 64'd8);
      chk("scroll.slot0", 64'(line_s[7:0]), 64'h09);
      chk("scroll.slot7", 64'(line_s[63:56]), 64'h02);
      chk("reject.slot0", 64'(line_r[7:0]), 64'h08);
      chk("reject.err", 64'(err_r), 64'd1);
      idle(1);
      chk("reject.err_drop", 64'(err_r), 64'd0);

      // Replace newest on count 2, then on an empty line.
      do_reset();
      idle(3);
      push_c(8'hA1);
      push_c(8'hB2);
      bs_btn = 1'b1;
      idle(2);
      push_c(8'h7E);
      chk("repl.slot0", 64'(line_s[7:0]), 64'h7E);
      chk("repl.count", 64'(count_s), 64'd2);
      bs_btn = 1'b0;
      do_reset();
      idle(3);
      bs_btn = 1'b1;
      idle(2);
      push_c(8'h7E);
      chk("repl0.slot0", 64'(line_s[7:0]), 64'h7E);
      chk("repl0.count", 64'(count_s), 64'd1);
      bs_btn = 1'b0;

      // Clear beats a simultaneous push and backspace edge.
      do_reset();
      idle(3);
      push_c(8'h01);
      push_c(8'h02);
      push_c(8'h03);
      bs_btn = 1'b1;
      idle(2);
      clear = 1'b1;
      push = 1'b1;
      push_char = 8'h55;
      tick();
      chk("clr.line", line_s, 64'h0);
      chk("clr.count", 64'(count_s), 64'd0);
      chk("clr.empty", 64'(empty_s), 64'd1);
      chk("clr.err", 64'(err_r), 64'd0);
      idle(1);
      bs_btn = 1'b0;

      // Button held through reset produces no backspace; reset mid-sequence.
      bs_btn = 1'b1;
      do_reset();
      push_c(8'hC1);
      push_c(8'hC2);
      push_c(8'hC3);
      idle(5);
      chk("hold.count", 64'(count_s), 64'd3);
      bs_btn = 1'b0;
      push_c(8'hC4);
      push_c(8'hC5);
      chk("mid.count5", 64'(count_s), 64'd5);
      rst = 1'b1;
      push = 1'b1;
      push_char = 8'hEE;
      tick();
      rst = 1'b0;
      push = 1'b0;
      chk("mid.rst.count", 64'(count_s), 64'd0);
      chk("mid.rst.line", line_s, 64'h0);
      idle(1);
      chk("mid.post.empty", 64'(empty_s), 64'd1);

      // Randomised traffic checked against the model every cycle.
      bs_left = 0;
      for (int n = 0; n < 800; n++) begin
         if (bs_left == 0) begin
            bs_btn  = ~bs_btn;
            bs_left = int'($urandom_range(1, 6));
         end
         bs_left--;
         rst       = ($urandom_range(0, 99) == 0);
         clear     = ($urandom_range(0, 29) == 0);
         push      = ($urandom_range(0, 2) != 0);
         push_char = 8'($urandom);
         tick();
      end
      rst = 1'b0;
      idle(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
